// File: rtl/sha256_pkg.sv
// sha256_pkg: widths, padder state encoding and a keep-mask byte counter shared by the SHA-256 front end.
package sha256_pkg;
    localparam int WORD_W        = 32;
    localparam int WORDS_PER_BLK = 16;
    localparam int LEN_W         = 64;
    localparam int BLK_W         = WORD_W * WORDS_PER_BLK;

    typedef enum logic [1:0] {PAD_FILL, PAD_OUT, PAD_EXTRA} pad_state_e;

    function automatic logic [2:0] keep_bytes(input logic [3:0] keep);
        return 3'(keep[3]) + 3'(keep[2]) + 3'(keep[1]) + 3'(keep[0]);
    endfunction
endpackage

// File: rtl/sha256_padder_if.sv
// sha256_padder_if: beat stream in, padded 512-bit block stream out.
interface sha256_padder_if;
    import sha256_pkg::*;
    logic [WORD_W-1:0] s_data_i;
    logic [3:0]        s_keep_i;
    logic              s_last_i;
    logic              s_valid_i;
    logic              s_ready_o;
    logic [BLK_W-1:0]  m_block_o;
    logic              m_valid_o;
    logic              m_ready_i;
    logic              m_first_o;
    logic              m_last_o;

    modport slave (
        input  s_data_i, s_keep_i, s_last_i, s_valid_i, m_ready_i,
        output s_ready_o, m_block_o, m_valid_o, m_first_o, m_last_o
    );
    modport master (
        output s_data_i, s_keep_i, s_last_i, s_valid_i, m_ready_i,
        input  s_ready_o, m_block_o, m_valid_o, m_first_o, m_last_o
    );
endinterface

// File: rtl/sha256_pad_word.sv
// sha256_pad_word: masks the final beat and inserts the 0x80 marker byte after its last valid byte.
// With SHA256_PAD_BYTE_EN undefined the keep mask is ignored and the marker never fits in the word.
module sha256_pad_word
    import sha256_pkg::*;
(
    input  logic [WORD_W-1:0] i_word,
    input  logic [3:0]        i_keep,
    output logic [WORD_W-1:0] o_word,
    output logic              o_mark_fits
);
`ifdef SHA256_PAD_BYTE_EN
    always_comb begin
        o_mark_fits = i_keep != 4'b1111;
        o_word      = (i_keep == 4'b1110) ? {i_word[31:8], 8'h80} :
                      (i_keep == 4'b1100) ? {i_word[31:16], 16'h8000} :
                      (i_keep == 4'b1000) ? {i_word[31:24], 24'h80_0000} :
                      (i_keep == 4'b0000) ? 32'h8000_0000 : i_word;
    end
`else
    logic w_unused_keep;
    assign w_unused_keep = ^i_keep;
    assign o_word        = i_word;
    assign o_mark_fits   = 1'b0;
`endif
endmodule

// File: rtl/sha256_padder.sv
// sha256_padder: FIPS 180-4 message padding into 512-bit blocks for sha256_core.
// Define SHA256_PAD_BYTE_EN for byte-granular messages via s_keep_i; otherwise messages are whole words.
module sha256_padder
    import sha256_pkg::*;
(
    input  logic           clk_i,
    input  logic           rst_i,
    sha256_padder_if.slave bus
);
    pad_state_e        r_state, w_state_next;
    logic [WORD_W-1:0] r_buf [WORDS_PER_BLK];
    logic [WORD_W-1:0] w_fill [WORDS_PER_BLK];
    logic [3:0]        r_widx;
    logic [LEN_W-1:0]  r_len, w_len_next;
    logic              r_first_pend, r_pad_pend, r_mark_pend, r_first, r_last;
    logic [WORD_W-1:0] w_pw;
    logic              w_fits, w_beat, w_hs, w_complete;

    sha256_pad_word u_pad_word (
        .i_word      (bus.s_data_i),
        .i_keep      (bus.s_keep_i),
        .o_word      (w_pw),
        .o_mark_fits (w_fits)
    );

    assign bus.s_ready_o = (r_state == PAD_FILL) && !rst_i;
    assign bus.m_valid_o = r_state != PAD_FILL;
    assign bus.m_first_o = r_first;
    assign bus.m_last_o  = r_last;
    assign w_beat        = bus.s_valid_i && bus.s_ready_o;
    assign w_hs          = bus.m_valid_o && bus.m_ready_i;
`ifdef SHA256_PAD_BYTE_EN
    assign w_len_next = r_len + (bus.s_last_i ? LEN_W'({keep_bytes(bus.s_keep_i), 3'b000}) : LEN_W'(WORD_W));
`else
    assign w_len_next = r_len + LEN_W'(WORD_W);
`endif
    // Length fits in this block only if the marker word lands at index 13 or lower
    assign w_complete = w_fits ? (r_widx <= 4'd13) : (r_widx <= 4'd12);

    always_comb begin
        for (int j = 0; j < WORDS_PER_BLK; j++) begin
            w_fill[j] = (j == int'(r_widx) + 1 && !w_fits) ? 32'h8000_0000 :
                        (w_complete && j == 14) ? w_len_next[LEN_W-1:WORD_W] :
                        (w_complete && j == 15) ? w_len_next[WORD_W-1:0] : '0;
            bus.m_block_o[(WORDS_PER_BLK-1-j)*WORD_W +: WORD_W] = r_buf[j];
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (r_state == PAD_FILL)
            w_state_next = (w_beat && (bus.s_last_i || r_widx == 4'd15)) ? PAD_OUT : PAD_FILL;
        else if (w_hs)
            w_state_next = (r_state == PAD_OUT && r_pad_pend) ? PAD_EXTRA : PAD_FILL;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= PAD_FILL;
        else       r_state <= w_state_next;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int j = 0; j < WORDS_PER_BLK; j++) r_buf[j] <= '0;
            r_widx       <= '0;
            r_len        <= '0;
            r_first_pend <= 1'b1;
            r_pad_pend   <= 1'b0;
            r_mark_pend  <= 1'b0;
            r_first      <= 1'b0;
            r_last       <= 1'b0;
        end else if (w_beat) begin
            r_buf[r_widx] <= bus.s_last_i ? w_pw : bus.s_data_i;
            r_len         <= w_len_next;
            r_widx        <= r_widx + 4'd1;
            r_last        <= bus.s_last_i && w_complete;
            r_pad_pend    <= bus.s_last_i && !w_complete;
            r_mark_pend   <= bus.s_last_i && !w_fits && r_widx == 4'd15;
            if (bus.s_last_i || r_widx == 4'd15) r_first <= r_first_pend;
            if (bus.s_last_i)
                for (int j = 0; j < WORDS_PER_BLK; j++)
                    if (j > int'(r_widx)) r_buf[j] <= w_fill[j];
        end else if (w_hs) begin
            r_first_pend <= r_last;
            r_first      <= 1'b0;
            if (r_state == PAD_OUT && r_pad_pend) begin
                r_buf[0] <= r_mark_pend ? 32'h8000_0000 : '0;
                for (int j = 1; j < 14; j++) r_buf[j] <= '0;
                r_buf[14] <= r_len[LEN_W-1:WORD_W];
                r_buf[15] <= r_len[WORD_W-1:0];
                r_last    <= 1'b1;
            end else begin
                // Length accumulates across data blocks and restarts only after the final block
                if (r_last) r_len <= '0;
                r_widx      <= '0;
                r_pad_pend  <= 1'b0;
                r_mark_pend <= 1'b0;
                r_last      <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sha256_padder.sv
// tb_sha256_padder: scoreboard bench; expected blocks come from a byte-level FIPS 180-4 padding model.
module tb_sha256_padder;
    import sha256_pkg::*;

    typedef struct packed {
        logic [BLK_W-1:0] blk;
        logic             first;
        logic             last;
    } exp_t;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    sha256_padder_if bus();
    sha256_padder dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));

    always #5 clk_i = ~clk_i;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    exp_t        exp_q[$];
    int          hs_cyc[$];
    logic [31:0] msg[$];
    logic [3:0]  msg_keep;

    always @(posedge clk_i) cyc <= cyc + 1;

    always @(negedge clk_i) begin
        exp_t e;
        if (!rst_i && bus.m_valid_o && bus.m_ready_i) begin
            hs_cyc.push_back(cyc);
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_block got %h", bus.m_block_o);
            end else begin
                e = exp_q.pop_front();
                if (bus.m_block_o !== e.blk) begin
                    n_fail++;
                    $display("FAIL block got %h required %h", bus.m_block_o, e.blk);
                end
                n_tests++;
                if (bus.m_first_o !== e.first) begin
                    n_fail++;
                    $display("FAIL first_flag got %b required %b", bus.m_first_o, e.first);
                end
                n_tests++;
                if (bus.m_last_o !== e.last) begin
                    n_fail++;
                    $display("FAIL last_flag got %b required %b", bus.m_last_o, e.last);
                end
            end
        end
    end

    task automatic push_expected();
        byte unsigned b[$];
        logic [63:0]  bits;
        logic [31:0]  w;
        int           nb;
        int           nblk;
        exp_t         e;
        for (int i = 0; i < msg.size(); i++) begin
            w = msg[i];
`ifdef SHA256_PAD_BYTE_EN
            nb = (i == msg.size() - 1) ? $countones(msg_keep) : 4;
`else
            nb = 4;
`endif
            for (int k = 0; k < nb; k++) b.push_back(w[31-8*k -: 8]);
        end
        bits = 64'(b.size()) * 64'd8;
        b.push_back(8'h80);
        while (b.size() % 64 != 56) b.push_back(8'h00);
        for (int k = 7; k >= 0; k--) b.push_back(bits[8*k +: 8]);
        nblk = b.size() / 64;
        for (int n = 0; n < nblk; n++) begin
            for (int k = 0; k < 64; k++) e.blk[511-8*k -: 8] = b[64*n+k];
            e.first = (n == 0);
            e.last  = (n == nblk - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic fill_msg(input int n, input logic [3:0] keep);
        msg.delete();
        for (int i = 0; i < n; i++) msg.push_back($urandom);
        msg_keep = keep;
    endtask

    task automatic drive_beats(input int lo, input int hi);
        int t;
        for (int i = lo; i <= hi; i++) begin
            t = 0;
            bus.s_valid_i = 1'b1;
            bus.s_data_i  = msg[i];
            bus.s_last_i  = (i == msg.size() - 1);
            bus.s_keep_i  = bus.s_last_i ? msg_keep : 4'b1111;
            @(negedge clk_i);
            while (!bus.s_ready_o && t < 200) begin
                @(negedge clk_i);
                t++;
            end
            if (!bus.s_ready_o) begin
                n_tests++;
                n_fail++;
                $display("FAIL beat_accept timeout at beat %0d", i);
            end
            @(posedge clk_i);
            #1;
        end
        bus.s_valid_i = 1'b0;
        bus.s_last_i  = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(posedge clk_i);
            t++;
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain pending %0d required 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_reset_values(input string name);
        n_tests++;
        if ({bus.m_valid_o, bus.m_first_o, bus.m_last_o, bus.s_ready_o} !== 4'b0000 || bus.m_block_o !== '0) begin
            n_fail++;
            $display("FAIL %s valid/first/last/ready got %b%b%b%b block %h required 0000 and zero",
                     name, bus.m_valid_o, bus.m_first_o, bus.m_last_o, bus.s_ready_o, bus.m_block_o);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        check_reset_values("reset");
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        n_tests++;
        if (bus.s_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_reset got %b required 1", bus.s_ready_o);
        end
    endtask

    task automatic test_abc();
        msg.delete();
        msg.push_back(32'h6162_6300);
        msg_keep = 4'b1110;
        push_expected();
        drive_beats(0, 0);
        n_tests++;
        if ({bus.m_valid_o, bus.m_first_o, bus.m_last_o} !== 3'b111) begin
            n_fail++;
            $display("FAIL abc_valid_flags got %b%b%b required 111", bus.m_valid_o, bus.m_first_o, bus.m_last_o);
        end
        @(posedge clk_i);
        #1;
        n_tests++;
        if ({bus.s_ready_o, bus.m_valid_o} !== 2'b10) begin
            n_fail++;
            $display("FAIL abc_turnaround ready/valid got %b%b required 10", bus.s_ready_o, bus.m_valid_o);
        end
        wait_drain();
    endtask

`ifdef SHA256_PAD_BYTE_EN
    task automatic test_empty();
        msg.delete();
        msg.push_back(32'hdead_beef);
        msg_keep = 4'b0000;
        push_expected();
        drive_beats(0, 0);
        wait_drain();
    endtask
`endif

    task automatic test_lengths();
        fill_msg(14, 4'b1111);
        push_expected();
        drive_beats(0, 13);
        wait_drain();
        fill_msg(15, 4'b1111);
        push_expected();
        drive_beats(0, 14);
        wait_drain();
        fill_msg(14, 4'b1000);
        push_expected();
        drive_beats(0, 13);
        wait_drain();
    endtask

    task automatic test_64();
        hs_cyc.delete();
        fill_msg(16, 4'b1111);
        push_expected();
        drive_beats(0, 15);
        wait_drain();
        n_tests++;
        if (hs_cyc.size() != 2) begin
            n_fail++;
            $display("FAIL b64_block_count got %0d required 2", hs_cyc.size());
        end else if (hs_cyc[1] - hs_cyc[0] != 1) begin
            n_fail++;
            $display("FAIL b64_extra_gap got %0d required 1", hs_cyc[1] - hs_cyc[0]);
        end
    endtask

    task automatic test_backpressure();
        logic [BLK_W-1:0] snap_blk;
        logic             snap_first;
        logic             snap_last;
        fill_msg(20, 4'b1100);
        push_expected();
        bus.m_ready_i = 1'b0;
        drive_beats(0, 15);
        snap_blk   = bus.m_block_o;
        snap_first = bus.m_first_o;
        snap_last  = bus.m_last_o;
        bus.s_valid_i = 1'b1;
        bus.s_data_i  = msg[16];
        bus.s_keep_i  = 4'b1111;
        repeat (5) begin
            @(posedge clk_i);
            #1;
            n_tests++;
            if (bus.m_block_o !== snap_blk || {bus.m_valid_o, bus.s_ready_o, bus.m_first_o, bus.m_last_o} !== {2'b10, snap_first, snap_last}) begin
                n_fail++;
                $display("FAIL stall_hold valid/ready/first/last got %b%b%b%b required 10%b%b", bus.m_valid_o,
                         bus.s_ready_o, bus.m_first_o, bus.m_last_o, snap_first, snap_last);
            end
        end
        bus.m_ready_i = 1'b1;
        drive_beats(16, 19);
        wait_drain();
    endtask

    task automatic test_reset_mid();
        fill_msg(10, 4'b1111);
        drive_beats(0, 6);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        check_reset_values("reset_mid");
        rst_i = 1'b0;
        test_abc();
    endtask

    task automatic test_back_to_back();
        fill_msg(3, 4'b1100);
        push_expected();
        drive_beats(0, 2);
        fill_msg(17, 4'b1000);
        push_expected();
        drive_beats(0, 16);
        fill_msg(1, 4'b1111);
        push_expected();
        drive_beats(0, 0);
        wait_drain();
    endtask

    initial begin
        bus.s_valid_i = 1'b0;
        bus.s_data_i  = '0;
        bus.s_keep_i  = 4'b1111;
        bus.s_last_i  = 1'b0;
        bus.m_ready_i = 1'b1;
        test_reset();
        test_abc();
`ifdef SHA256_PAD_BYTE_EN
        test_empty();
`endif
        test_lengths();
        test_64();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
endmodule

// File: doc/sha256_padder.md
# sha256_padder

Message-preprocessing stage directly upstream of `sha256_core`. It accepts a big-endian message as a stream of 32-bit beats and applies FIPS 180-4 padding: a 0x80 byte, zero fill, and a 64-bit bit-length. It emits 512-bit blocks through a valid/ready handshake. Block order and flags let the core controller chain multi-block messages (`m_first_o` re-initialises H, `m_last_o` marks the digest block).

## Interface
- No parameters. Widths come from `sha256_pkg`.
- `clk_i` in 1: clock; all logic on rising edge.
- `rst_i` in 1: synchronous, active-high reset.
- `s_data_i` in 32: message beat; byte 0 is `[31:24]`.
- `s_keep_i` in 4: valid bytes on the last beat, contiguous from MSB: 1111, 1110, 1100, 1000, or 0000 (empty tail). Sampled only when `s_last_i`.
- `s_last_i` in 1: final beat of the message.
- `s_valid_i` in 1: beat valid.
- `s_ready_o` out 1: beat accepted when `s_valid_i && s_ready_o`.
- `m_block_o` out 512: padded block; word 0 is at `[511:480]`.
- `m_valid_o` out 1: block valid.
- `m_ready_i` in 1: block consumed when `m_valid_o && m_ready_i`.
- `m_first_o` out 1: block is the first of its message.
- `m_last_o` out 1: block is the final (length-bearing) block.

## Operation
- Buffer: 16×32 word registers and a word index `widx` in 0..15.
- Length counter: 64-bit bit count, adds 32 per non-last beat and 8×popcount(keep) on the last beat. Wraps mod 2^64.
- Flag `first_pend`: set at reset and after each `m_last_o` handshake; cleared after any block handshake.
- States: FILL, OUT, EXTRA.
- FILL, non-last beat: write the word at `widx` and increment. If `widx` was 15, go to OUT as a full-data block.
- FILL, last beat, 0x80 insertion:
  - keep=1111: the beat is stored whole, and 0x80000000 goes into the next word.
  - Other keep values: 0x80 is placed in the byte after the last valid byte of the same word; lower bytes are zero.
- FILL, last beat, block completion:
  - The 0x80-bearing word at index ≤13: zero words up to index 13; words 14–15 hold the length; `m_last_o`=1; go to OUT.
  - Otherwise: zero the remainder of the block and latch `pad_pend`. If the 0x80 word did not fit (keep=1111 at index 15), also latch `mark_pend`. Go to OUT with `m_last_o`=0.
- All padding for a beat is written in the same cycle the beat is accepted.
- OUT: hold `m_block_o` and flags stable until the handshake. Then:
  - If `pad_pend`: build the extra block — word 0 = 0x80000000 if `mark_pend`, else 0; words 1–13 zero; words 14–15 the length. Go to EXTRA.
  - Else: clear the length counter and `widx`, go to FILL.
- EXTRA: present the extra block with `m_last_o`=1. On handshake, go to FILL and clear all pending state.
- A beat with keep ∉ {1111, 1110, 1100, 1000, 0000} on the last beat is illegal; behaviour is unspecified.

## Timing
- `s_ready_o` = (state==FILL) && !`rst_i`: one beat per cycle, no bubbles.
- `m_valid_o` rises the cycle after the 16th word or last beat is accepted. The extra block follows one cycle after the preceding handshake.
- Block-to-FILL turnaround is one cycle: `s_ready_o` is high the cycle after the final handshake.
- Reset values: `m_valid_o`=0, `m_block_o`=0, `m_first_o`=0, `m_last_o`=0; state FILL, `widx`=0, length 0, `first_pend`=1.
- Reset mid-message or mid-OUT discards all data. No partial block is emitted.
- `m_ready_i` held high: one block per handshake cycle, no gap inside OUT.

## Configuration
- `SHA256_PAD_BYTE_EN` defined: `s_keep_i` is honoured, giving byte-granular messages, including the empty message (keep=0000).
- Not defined: `s_keep_i` is ignored and treated as 1111. Messages are whole 32-bit words, and each beat adds 32 to the length. The byte-insert mux is removed.

## Structure
- Add to `sha256_pkg`: `WORD_W`=32, `WORDS_PER_BLK`=16, `LEN_W`=64, and enum `pad_state_e {PAD_FILL, PAD_OUT, PAD_EXTRA}`.
- One sub-module, `sha256_pad_word`: combinational; takes word and keep, returns the masked word with 0x80 inserted plus a `mark_fits` flag.

## Test plan
- "abc": beat 0x61626300, keep 1110, last → block 61626380, words 1–14 zero, word 15 = 0x18; first=last=1. Feeding it to `sha256_core` gives ba7816bf…f20015ad.
- Empty (macro on): keep 0000, last → block 80000000, all remaining words zero including the length. The core digest is e3b0c442…7852b855.
- 56-byte message (14 full words) → block 1 has word 14 = 0x80000000, word 15 = 0, first=1, last=0. Block 2 is zeros with length 0x1C0, last=1.
- 64-byte message → block 1 is pure data. Block 2 word 0 = 0x80000000, length 0x200, one cycle after the block 1 handshake.
- Backpressure: `m_ready_i` low for 5 cycles → `m_block_o` and flags stable, `s_ready_o`=0, no beat lost.
- Assert `rst_i` after 7 beats → outputs at reset values next cycle. A following "abc" yields the correct single block with first=1.
